// File: rtl/periph_bus_fifo.sv
// periph_bus_fifo: memory-mapped timer, LED/switch/7-segment registers and a queued UART byte channel.
// Build option PERIPH_UART_FIFO_EN: UART FIFOs are FIFO_DEPTH deep; otherwise single-entry buffers.

module periph_bus_fifo_q #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         sysclk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         overflow
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [2**PW];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // a pop frees the slot a same-cycle push needs, so a full queue still accepts it
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign overflow = push & ~do_push;
    assign dout     = mem[rd_ptr];

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge sysclk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push & ~do_pop)      count <= count + 1'b1;
            else if (do_pop & ~do_push) count <= count - 1'b1;
        end
    end
endmodule

module periph_bus_fifo #(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int          TIMER_W    = 32,
    parameter int          LED_W      = 8,
    parameter int          SW_W       = 8,
    parameter int          DIGI_W     = 12,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [7:0]        uart_tx_data,
    output logic              uart_tx_start,
    input  logic              uart_tx_busy,
    input  logic [7:0]        uart_rx_data,
    input  logic              uart_rx_valid,
    output logic [LED_W-1:0]  led,
    input  logic [SW_W-1:0]   switch,
    output logic [DIGI_W-1:0] digi,
    output logic              irqout,
    input  logic              PC_31
);
`ifdef PERIPH_UART_FIFO_EN
    localparam int Q_DEPTH = FIFO_DEPTH;
`else
    // single-entry buffers regardless of FIFO_DEPTH
    localparam int Q_DEPTH = (FIFO_DEPTH > 1) ? 1 : 1;
`endif

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_HOLD} tx_state_t;

    logic sel_th, sel_tl, sel_tcon, sel_led, sel_sw, sel_digi, sel_txd, sel_rxd, sel_ucon;
    logic [TIMER_W-1:0] th;
    logic [TIMER_W-1:0] tl;
    logic [2:0]         tcon;
    logic               tl_wrap;
    logic               rx_irq_en, rx_ovf, tx_ovf;
    logic [7:0]         tx_dout, rx_dout;
    logic               tx_full, tx_empty, tx_drop, tx_pop;
    logic               rx_full, rx_empty, rx_drop, rx_pop;
    tx_state_t          tx_state;

    assign sel_th   = (addr == BASE_ADDR + 32'h00);
    assign sel_tl   = (addr == BASE_ADDR + 32'h04);
    assign sel_tcon = (addr == BASE_ADDR + 32'h08);
    assign sel_led  = (addr == BASE_ADDR + 32'h0C);
    assign sel_sw   = (addr == BASE_ADDR + 32'h10);
    assign sel_digi = (addr == BASE_ADDR + 32'h14);
    assign sel_txd  = (addr == BASE_ADDR + 32'h18);
    assign sel_rxd  = (addr == BASE_ADDR + 32'h1C);
    assign sel_ucon = (addr == BASE_ADDR + 32'h20);

    assign tl_wrap = tcon[0] & (tl == '1);
    assign rx_pop  = rd & sel_rxd;
    assign tx_pop  = (tx_state == TX_IDLE) & ~tx_empty;

    periph_bus_fifo_q #(.DEPTH(Q_DEPTH), .W(8)) u_tx_q (
        .sysclk(sysclk), .reset(reset), .push(wr & sel_txd), .pop(tx_pop), .din(wdata[7:0]),
        .dout(tx_dout), .full(tx_full), .empty(tx_empty), .overflow(tx_drop)
    );

    periph_bus_fifo_q #(.DEPTH(Q_DEPTH), .W(8)) u_rx_q (
        .sysclk(sysclk), .reset(reset), .push(uart_rx_valid), .pop(rx_pop), .din(uart_rx_data),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty), .overflow(rx_drop)
    );

    always_ff @(posedge sysclk) begin
        if (reset) begin
            th        <= '0;
            tl        <= '0;
            tcon      <= '0;
            led       <= '0;
            digi      <= '0;
            rx_irq_en <= 1'b0;
            rx_ovf    <= 1'b0;
            tx_ovf    <= 1'b0;
            irqout    <= 1'b0;
        end else begin
            if (wr & sel_th) th <= wdata[TIMER_W-1:0];
            // bus writes take priority over the running timer
            if (wr & sel_tl)   tl <= wdata[TIMER_W-1:0];
            else if (tl_wrap)  tl <= th;
            else if (tcon[0])  tl <= tl + 1'b1;
            if (wr & sel_tcon)            tcon    <= wdata[2:0];
            else if (tl_wrap & tcon[1])   tcon[2] <= 1'b1;
            if (wr & sel_led)  led  <= wdata[LED_W-1:0];
            if (wr & sel_digi) digi <= wdata[DIGI_W-1:0];
            if (wr & sel_ucon) rx_irq_en <= wdata[0];
            if (rx_drop)                            rx_ovf <= 1'b1;
            else if (wr & sel_ucon & wdata[3])      rx_ovf <= 1'b0;
            if (tx_drop)                            tx_ovf <= 1'b1;
            else if (wr & sel_ucon & wdata[5])      tx_ovf <= 1'b0;
            irqout <= ~PC_31 & (tcon[2] | (rx_irq_en & ~rx_empty));
        end
    end

    // state    | meaning
    // TX_IDLE  | waiting for a queued byte; pops it and latches uart_tx_data
    // TX_START | uart_tx_start high for this one cycle
    // TX_HOLD  | waiting for the sender to drop uart_tx_busy
    always_ff @(posedge sysclk) begin
        if (reset) begin
            tx_state      <= TX_IDLE;
            uart_tx_start <= 1'b0;
            uart_tx_data  <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: if (~tx_empty) begin
                    uart_tx_data  <= tx_dout;
                    uart_tx_start <= 1'b1;
                    tx_state      <= TX_START;
                end
                TX_START: begin
                    uart_tx_start <= 1'b0;
                    tx_state      <= TX_HOLD;
                end
                TX_HOLD: if (~uart_tx_busy) tx_state <= TX_IDLE;
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_th)        rdata = 32'(th);
            else if (sel_tl)   rdata = 32'(tl);
            else if (sel_tcon) rdata = 32'(tcon);
            else if (sel_led)  rdata = 32'(led);
            else if (sel_sw)   rdata = 32'(switch);
            else if (sel_digi) rdata = 32'(digi);
            else if (sel_rxd)  rdata = rx_empty ? 32'd0 : 32'(rx_dout);
            else if (sel_ucon) rdata = {26'd0, tx_ovf, ~rx_empty, rx_ovf, tx_empty, tx_full, rx_irq_en};
        end
    end

    logic unused_rx_full;
    assign unused_rx_full = rx_full;
endmodule

// File: tb/tb_periph_bus_fifo.sv
// Self-checking bench for periph_bus_fifo: directed register/timer/UART steps plus a randomized
// RX traffic phase checked against a queue model; a sender model answers start pulses with busy.
`timescale 1ns/1ps
module tb_periph_bus_fifo;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int FD = 8;
`ifdef PERIPH_UART_FIFO_EN
    localparam int D = FD;
`else
    localparam int D = 1;
`endif
    localparam int BUSY_CYC = 10;
    localparam logic [31:0] A_TH   = BASE + 32'h00;
    localparam logic [31:0] A_TL   = BASE + 32'h04;
    localparam logic [31:0] A_TCON = BASE + 32'h08;
    localparam logic [31:0] A_LED  = BASE + 32'h0C;
    localparam logic [31:0] A_SW   = BASE + 32'h10;
    localparam logic [31:0] A_DIGI = BASE + 32'h14;
    localparam logic [31:0] A_TXD  = BASE + 32'h18;
    localparam logic [31:0] A_RXD  = BASE + 32'h1C;
    localparam logic [31:0] A_UCON = BASE + 32'h20;

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_start;
    logic        uart_tx_busy = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        uart_rx_valid = 1'b0;
    logic [7:0]  led;
    logic [7:0]  switch = '0;
    logic [11:0] digi;
    logic        irqout;
    logic        PC_31 = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] sent[$];
    int         start_cyc[$];
    int         busy_cnt = 0;
    int         start_while_busy = 0;

    periph_bus_fifo #(.BASE_ADDR(BASE), .TIMER_W(32), .LED_W(8), .SW_W(8), .DIGI_W(12),
                      .FIFO_DEPTH(FD)) dut (
        .sysclk(sysclk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start),
        .uart_tx_busy(uart_tx_busy), .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
        .led(led), .switch(switch), .digi(digi), .irqout(irqout), .PC_31(PC_31)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc++;

    // sender model: captures each start pulse, then holds busy for BUSY_CYC cycles
    initial forever begin
        @(negedge sysclk);
        if (uart_tx_start === 1'b1) begin
            if (busy_cnt != 0) start_while_busy++;
            sent.push_back(uart_tx_data);
            start_cyc.push_back(cyc);
            busy_cnt = BUSY_CYC;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        uart_tx_busy = (busy_cnt != 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        step();
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; rd = 1'b1;
        #1;
        d = rdata;
        step();
        rd = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        chk(tag, v, exp);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] r;
        logic [7:0]  s;
        logic [7:0]  b;
        logic [7:0]  txb[$];
        logic [7:0]  rxq[$];
        logic        rx_ovf_m;
        logic        vld;
        int          op;
        int          n;
        int          n0;

        repeat (3) step();
        reset = 1'b0;

        chk("rst_irqout", 32'(irqout), 0);
        chk("rst_tx_start", 32'(uart_tx_start), 0);
        chk("rst_tx_data", 32'(uart_tx_data), 0);
        chk("rst_led", 32'(led), 0);
        chk("rst_digi", 32'(digi), 0);
        for (int i = 0; i < 9; i++)
            read_chk("rst_reg", BASE + 32'(4 * i), (i == 8) ? 32'h4 : 32'h0);
        read_chk("unmapped", BASE + 32'h24, 0);

        // timer wrap and interrupt
        bus_write(A_TH, 32'hFFFF_FFFD);
        bus_write(A_TL, 32'hFFFF_FFFE);
        bus_write(A_TCON, 32'h3);
        step();
        step();
        read_chk("tl_wrap", A_TL, 32'hFFFF_FFFD);
        chk("timer_irq", 32'(irqout), 1);
        read_chk("tcon_status", A_TCON, 32'h7);
        PC_31 = 1'b1;
        step();
        chk("irq_masked", 32'(irqout), 0);
        PC_31 = 1'b0;
        bus_write(A_TCON, 32'h0);
        step();
        step();
        chk("irq_cleared", 32'(irqout), 0);
        addr = A_TH; rd = 1'b0;
        #1;
        chk("rd_low_zero", rdata, 0);

        // random register traffic
        for (int i = 0; i < 6; i++) begin
            r = $urandom;
            bus_write(A_LED, r);
            chk("led_port", 32'(led), {24'd0, r[7:0]});
            read_chk("led_rd", A_LED, {24'd0, r[7:0]});
            r = $urandom;
            bus_write(A_DIGI, r);
            chk("digi_port", 32'(digi), {20'd0, r[11:0]});
            read_chk("digi_rd", A_DIGI, {20'd0, r[11:0]});
            r = $urandom;
            bus_write(A_TH, r);
            read_chk("th_rd", A_TH, r);
            s = 8'($urandom);
            switch = s;
            read_chk("sw_rd", A_SW, {24'd0, s});
        end

        // TX: three bytes, software waits while tx_full
        sent.delete();
        start_cyc.delete();
        bus_write(A_TXD, 32'h41);
        chk("tx_start_early", 32'(uart_tx_start), 0);
        step();
        chk("tx_start_lat", 32'(uart_tx_start), 1);
        chk("tx_data_first", 32'(uart_tx_data), 32'h41);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                bus_read(A_UCON, v);
                n++;
            end while (v[1] && n < 100);
            chk("tx_full_wait", 32'(v[1]), 0);
            bus_write(A_TXD, 32'h42 + 32'(k));
        end
        n = 0;
        while (sent.size() < 3 && n < 200) begin
            step();
            n++;
        end
        chk("tx_count", 32'(sent.size()), 3);
        for (int i = 0; i < 3 && i < sent.size(); i++)
            chk("tx_order", 32'(sent[i]), 32'h41 + 32'(i));
        if (start_cyc.size() >= 2)
            chk("tx_gap", 32'(start_cyc[1] - start_cyc[0] > BUSY_CYC), 1);
        read_chk("tx_empty_after", A_UCON, 32'h04);

        // TX overflow: D+2 back-to-back pushes while the sender is busy drop exactly the last
        n = 0;
        while (busy_cnt != 0 && n < 100) begin
            step();
            n++;
        end
        step();
        step();
        sent.delete();
        txb.delete();
        for (int i = 0; i < D + 2; i++) txb.push_back(8'($urandom));
        for (int i = 0; i < D + 2; i++) bus_write(A_TXD, 32'(txb[i]));
        read_chk("tx_ovf_set", A_UCON, 32'h22);
        n = 0;
        while (sent.size() < D + 1 && n < 15 * (D + 2) + 50) begin
            step();
            n++;
        end
        chk("tx_ovf_count", 32'(sent.size()), 32'(D + 1));
        for (int i = 0; i < D + 1 && i < sent.size(); i++)
            chk("tx_ovf_order", 32'(sent[i]), 32'(txb[i]));
        bus_write(A_UCON, 32'h20);
        read_chk("tx_ovf_clr", A_UCON, 32'h04);

        // RX overflow
        for (int i = 0; i <= D; i++) begin
            uart_rx_valid = 1'b1;
            uart_rx_data = 8'(16 + i);
            step();
        end
        uart_rx_valid = 1'b0;
        read_chk("rx_ovf_set", A_UCON, 32'h1C);
        for (int i = 0; i < D; i++) read_chk("rx_pop", A_RXD, 32'(16 + i));
        read_chk("rx_empty_rd", A_RXD, 0);
        bus_write(A_UCON, 32'h08);
        read_chk("rx_ovf_clr", A_UCON, 32'h04);

        // RX full with a push coinciding with a pop
        for (int i = 0; i < D; i++) begin
            uart_rx_valid = 1'b1;
            uart_rx_data = 8'(32 + i);
            step();
        end
        uart_rx_valid = 1'b1;
        uart_rx_data = 8'h99;
        bus_read(A_RXD, v);
        uart_rx_valid = 1'b0;
        chk("coinc_head", v, 32'h20);
        read_chk("coinc_no_ovf", A_UCON, 32'h14);
        for (int i = 1; i < D; i++) read_chk("coinc_pop", A_RXD, 32'(32 + i));
        read_chk("coinc_new", A_RXD, 32'h99);
        read_chk("coinc_empty", A_RXD, 0);

        // receive interrupt
        bus_write(A_UCON, 32'h01);
        uart_rx_valid = 1'b1;
        uart_rx_data = 8'h5A;
        step();
        uart_rx_valid = 1'b0;
        chk("rx_irq_lag", 32'(irqout), 0);
        step();
        chk("rx_irq_on", 32'(irqout), 1);
        bus_read(A_RXD, v);
        chk("rx_irq_byte", v, 32'h5A);
        chk("rx_irq_hold", 32'(irqout), 1);
        step();
        chk("rx_irq_off", 32'(irqout), 0);
        bus_write(A_UCON, 32'h00);

        // randomized RX traffic against a queue model
        rxq.delete();
        rx_ovf_m = 1'b0;
        for (int c = 0; c < 300; c++) begin
            op  = $urandom_range(0, 2);
            vld = ($urandom_range(0, 1) == 1);
            b   = 8'($urandom);
            uart_rx_valid = vld;
            uart_rx_data = b;
            if (op == 1) begin addr = A_RXD; rd = 1'b1; end
            else if (op == 2) begin addr = A_UCON; rd = 1'b1; end
            #1;
            if (op == 1) chk("rnd_rxd", rdata, (rxq.size() != 0) ? 32'(rxq[0]) : 32'd0);
            if (op == 2)
                chk("rnd_ucon", rdata, {26'd0, 1'b0, rxq.size() != 0, rx_ovf_m, 1'b1, 1'b0, 1'b0});
            step();
            rd = 1'b0;
            uart_rx_valid = 1'b0;
            if (op == 1 && rxq.size() != 0) void'(rxq.pop_front());
            if (vld) begin
                if (rxq.size() < D) rxq.push_back(b);
                else rx_ovf_m = 1'b1;
            end
        end

        // reset in the middle of a transfer discards queued bytes
        n = 0;
        while (busy_cnt != 0 && n < 100) begin
            step();
            n++;
        end
        step();
        step();
        bus_write(A_TXD, 32'h77);
        bus_write(A_TXD, 32'h78);
        uart_rx_valid = 1'b1;
        uart_rx_data = 8'h33;
        step();
        uart_rx_valid = 1'b0;
        n0 = sent.size();
        reset = 1'b1;
        step();
        reset = 1'b0;
        read_chk("rst_mid_ucon", A_UCON, 32'h04);
        read_chk("rst_mid_rxd", A_RXD, 0);
        repeat (30) step();
        chk("rst_mid_nosend", 32'(sent.size()), 32'(n0));
        chk("rst_mid_led", 32'(led), 0);

        chk("start_while_busy", 32'(start_while_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
